nvm_fc_scheduler: RTL and testbench

NVM_FC_SCHEDULER -- requirements
Module: nvm_fc_scheduler

---
 rtl/nvm_fc_scheduler.sv | 173 +++++++++++++++++
 tb/tb_nvm_fc_scheduler.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvm_fc_scheduler.sv
// Flash-controller request scheduler: arbitrates host transfers against garbage
// collection, enforces per-region write protection and tracks transfer progress.
module nvm_fc_scheduler #(
    parameter int            NREG      = 4,
    parameter int            BW        = 16,
    parameter logic [BW-1:0] GC_THRESH = 16'hF000
) (
    input  logic                     CLK,
    input  logic                     nRST,
    // Host request: a transfer is taken on any cycle where req_valid and req_ready are both 1.
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [$clog2(NREG)-1:0]  req_region,
    input  logic [BW-1:0]            req_offset,
    input  logic [BW-1:0]            req_length,
    input  logic                     cfg_we,
    input  logic [$clog2(NREG)-1:0]  cfg_region,
    input  logic                     cfg_perm,
    input  logic                     beat,
    input  logic [BW-1:0]            w_used,
    input  logic                     r_full,
    input  logic                     gc_request,
    input  logic                     gc_interrupt,
    input  logic                     gc_done,
    output logic                     gc_ini,
    output logic                     gc_start,
    output logic                     remap_update,
    input  logic                     remap_done,
    input  logic                     remap_error,
    output logic [NREG-1:0]          wr_perm,
    output logic [2:0]               sys_mode,
    output logic                     req_done,
    output logic                     err,
    output logic [BW-1:0]            txn_count,
    output logic [BW-1:0]            txn_offset,
    output logic [$clog2(NREG)-1:0]  txn_region
);
    localparam int RW = $clog2(NREG);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REMAP  = 3'd1,
        BUSY   = 3'd2,
        GC_INI = 3'd3,
        GC_RUN = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          rdy_en;
    logic          armed;
    logic          txn_write;
    logic [BW-1:0] txn_length;
    logic [BW-1:0] cnt;

    logic gc_trig;
    logic accept;
    logic sel_perm;
    logic req_bad;
    logic beat_cnt;
    logic last_beat;
    logic err_d;
    logic done_d;
    logic upd_d;

    // Out-of-range regions read as protected, so writes to them are rejected.
    always_comb begin
        sel_perm = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (req_region == RW'(i)) sel_perm = wr_perm[i];
        end
    end

    assign gc_trig   = gc_request | ((w_used >= GC_THRESH) & armed);
    assign req_ready = rdy_en & (state == IDLE) & ~gc_trig;
    assign accept    = req_valid & req_ready;
    assign req_bad   = (req_length == '0) | (req_write & ~sel_perm);
    // Reads stall while the read buffer is full; writes always drain.
    assign beat_cnt  = beat & (txn_write | ~r_full);
    assign last_beat = (state == BUSY) & beat_cnt & (cnt == BW'(1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (gc_trig)                 state_nx = GC_INI;
                else if (accept && !req_bad) state_nx = REMAP;
            end
            REMAP: begin
                if (remap_error)     state_nx = IDLE;
                else if (remap_done) state_nx = BUSY;
            end
            BUSY:    if (last_beat) state_nx = IDLE;
            GC_INI:  state_nx = GC_RUN;
            GC_RUN:  if (gc_done || gc_interrupt) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        err_d  = (accept & req_bad) | ((state == REMAP) & remap_error);
        done_d = last_beat;
        upd_d  = accept & ~req_bad;
    end

    assign gc_ini    = (state == GC_INI);
    assign gc_start  = (state == GC_RUN);
    assign sys_mode  = state;
    assign txn_count = cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err          <= 1'b0;
            req_done     <= 1'b0;
            remap_update <= 1'b0;
            rdy_en       <= 1'b0;
        end else begin
            err          <= err_d;
            req_done     <= done_d;
            remap_update <= upd_d;
            rdy_en       <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            txn_write  <= 1'b0;
            txn_region <= '0;
            txn_offset <= '0;
            txn_length <= '0;
            cnt        <= '0;
        end else begin
            if (accept) begin
                txn_write  <= req_write;
                txn_region <= req_region;
                txn_offset <= req_offset;
                txn_length <= req_length;
            end
            if (state == REMAP && remap_done && !remap_error)
                cnt <= txn_length;
            else if (state == BUSY && beat_cnt && cnt != '0)
                cnt <= cnt - BW'(1);
        end
    end

    // An interrupted GC disarms the threshold until usage falls back below it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            armed <= 1'b1;
        end else if (state == GC_RUN && gc_interrupt && !gc_done) begin
            armed <= 1'b0;
        end else if (w_used < GC_THRESH) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_perm <= '1;
        end else if (cfg_we) begin
            for (int i = 0; i < NREG; i++) begin
                if (cfg_region == RW'(i)) wr_perm[i] <= cfg_perm;
            end
        end
    end

endmodule

// File: tb/tb_nvm_fc_scheduler.sv
// Scenario-driven bench for nvm_fc_scheduler with a transaction-level model for
// randomized traffic.
module tb_nvm_fc_scheduler;
    localparam int NREG = 4;
    localparam int BW   = 16;
    localparam int RW   = 2;

    logic            CLK = 1'b0;
    logic            nRST = 1'b1;
    logic            req_valid = 1'b0, req_write = 1'b0;
    logic [RW-1:0]   req_region = '0;
    logic [BW-1:0]   req_offset = '0, req_length = '0;
    logic            cfg_we = 1'b0, cfg_perm = 1'b0;
    logic [RW-1:0]   cfg_region = '0;
    logic            beat = 1'b0, r_full = 1'b0;
    logic [BW-1:0]   w_used = '0;
    logic            gc_request = 1'b0, gc_interrupt = 1'b0, gc_done = 1'b0;
    logic            remap_done = 1'b0, remap_error = 1'b0;
    logic            req_ready, gc_ini, gc_start, remap_update, req_done, err;
    logic [NREG-1:0] wr_perm;
    logic [2:0]      sys_mode;
    logic [BW-1:0]   txn_count, txn_offset;
    logic [RW-1:0]   txn_region;

    int total = 0;
    int bad   = 0;
    int n_upd = 0, n_err = 0, n_done = 0, n_gcini = 0;
    logic [5:0] exp_q[$];

    nvm_fc_scheduler #(.NREG(NREG), .BW(BW), .GC_THRESH(16'hF000)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_region(req_region), .req_offset(req_offset), .req_length(req_length),
        .cfg_we(cfg_we), .cfg_region(cfg_region), .cfg_perm(cfg_perm),
        .beat(beat), .w_used(w_used), .r_full(r_full),
        .gc_request(gc_request), .gc_interrupt(gc_interrupt), .gc_done(gc_done),
        .gc_ini(gc_ini), .gc_start(gc_start),
        .remap_update(remap_update), .remap_done(remap_done), .remap_error(remap_error),
        .wr_perm(wr_perm), .sys_mode(sys_mode), .req_done(req_done), .err(err),
        .txn_count(txn_count), .txn_offset(txn_offset), .txn_region(txn_region)
    );

    always #5 CLK = ~CLK;

    // Pulse counters sampled mid-cycle.
    always @(negedge CLK) begin
        if (remap_update) n_upd   <= n_upd + 1;
        if (err)          n_err   <= n_err + 1;
        if (req_done)     n_done  <= n_done + 1;
        if (gc_ini)       n_gcini <= n_gcini + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, required finish before 500000");
        $fatal(1, "watchdog");
    end

    task tick();
        @(posedge CLK);
        #1;
    endtask

    task accept_req(input logic wr, input logic [RW-1:0] rg,
                    input logic [BW-1:0] off, input logic [BW-1:0] len);
        int t;
        req_valid = 1'b1; req_write = wr; req_region = rg;
        req_offset = off; req_length = len;
        #1;
        t = 0;
        while (!req_ready && t < 50) begin
            tick();
            t++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait: req_ready=%b required=1", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task complete_txn(input int len);
        remap_done = 1'b1;
        tick();
        remap_done = 1'b0;
        beat = 1'b1;
        repeat (len) tick();
        beat = 1'b0;
        total++;
        if (sys_mode !== 3'd0) begin
            bad++;
            $display("FAIL complete_idle: sys_mode=%0d required=0", sys_mode);
        end
        tick();
    endtask

    task test_reset();
        #2 nRST = 1'b0;
        repeat (2) tick();
        total++; if (sys_mode !== 3'd0) begin bad++; $display("FAIL rst_sys_mode: got=%0d exp=0", sys_mode); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready: got=%b exp=0", req_ready); end
        total++; if ({remap_update, gc_ini, gc_start, req_done, err} !== 5'b0) begin
            bad++; $display("FAIL rst_pulses: got=%b exp=00000", {remap_update, gc_ini, gc_start, req_done, err});
        end
        total++; if (wr_perm !== 4'b1111) begin bad++; $display("FAIL rst_wr_perm: got=%b exp=1111", wr_perm); end
        total++; if (txn_count !== 16'd0) begin bad++; $display("FAIL rst_count: got=%0d exp=0", txn_count); end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_early: got=%b exp=0", req_ready); end
        tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_first: got=%b exp=1", req_ready); end
    endtask

    task test_write_basic();
        int b_upd, b_done;
        b_upd = n_upd; b_done = n_done;
        accept_req(1'b1, 2'd1, 16'h0040, 16'd3);
        total++; if (sys_mode !== 3'd1) begin bad++; $display("FAIL wb_remap_mode: got=%0d exp=1", sys_mode); end
        total++; if (remap_update !== 1'b1) begin bad++; $display("FAIL wb_upd_pulse: got=%b exp=1", remap_update); end
        tick();
        total++; if (remap_update !== 1'b0) begin bad++; $display("FAIL wb_upd_end: got=%b exp=0", remap_update); end
        tick();
        remap_done = 1'b1;
        tick();
        remap_done = 1'b0;
        total++; if (sys_mode !== 3'd2) begin bad++; $display("FAIL wb_busy_mode: got=%0d exp=2", sys_mode); end
        total++; if (txn_count !== 16'd3) begin bad++; $display("FAIL wb_load: got=%0d exp=3", txn_count); end
        total++; if (txn_offset !== 16'h0040 || txn_region !== 2'd1) begin
            bad++; $display("FAIL wb_latch: off=%h rg=%0d exp off=0040 rg=1", txn_offset, txn_region);
        end
        beat = 1'b1;
        tick();
        total++; if (req_done !== 1'b0 || txn_count !== 16'd2) begin
            bad++; $display("FAIL wb_beat1: done=%b cnt=%0d exp done=0 cnt=2", req_done, txn_count);
        end
        tick();
        total++; if (req_done !== 1'b0) begin bad++; $display("FAIL wb_beat2: done=%b exp=0", req_done); end
        tick();
        beat = 1'b0;
        total++; if (req_done !== 1'b1 || sys_mode !== 3'd0) begin
            bad++; $display("FAIL wb_beat3: done=%b mode=%0d exp done=1 mode=0", req_done, sys_mode);
        end
        tick();
        total++; if (req_done !== 1'b0) begin bad++; $display("FAIL wb_done_end: got=%b exp=0", req_done); end
        total++; if (n_upd - b_upd != 1 || n_done - b_done != 1) begin
            bad++; $display("FAIL wb_counts: upd=%0d done=%0d exp 1 1", n_upd - b_upd, n_done - b_done);
        end
    endtask

    task test_perm();
        int b_upd;
        cfg_we = 1'b1; cfg_region = 2'd2; cfg_perm = 1'b0;
        tick();
        cfg_we = 1'b0;
        total++; if (wr_perm !== 4'b1011) begin bad++; $display("FAIL perm_write: got=%b exp=1011", wr_perm); end
        b_upd = n_upd;
        accept_req(1'b1, 2'd2, 16'd0, 16'd1);
        total++; if (err !== 1'b1 || sys_mode !== 3'd0 || remap_update !== 1'b0) begin
            bad++; $display("FAIL perm_reject: err=%b mode=%0d upd=%b exp 1 0 0", err, sys_mode, remap_update);
        end
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL perm_err_end: got=%b exp=0", err); end
        accept_req(1'b0, 2'd2, 16'd0, 16'd2);
        total++; if (remap_update !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL perm_read_ok: upd=%b err=%b exp 1 0", remap_update, err);
        end
        complete_txn(2);
        // permission raised in the accept cycle: old value (0) must still reject
        cfg_we = 1'b1; cfg_region = 2'd2; cfg_perm = 1'b1;
        accept_req(1'b1, 2'd2, 16'd0, 16'd1);
        cfg_we = 1'b0;
        total++; if (err !== 1'b1 || wr_perm !== 4'b1111) begin
            bad++; $display("FAIL perm_same_cycle: err=%b perm=%b exp 1 1111", err, wr_perm);
        end
        tick();
        accept_req(1'b0, 2'd0, 16'd0, 16'd0);
        total++; if (err !== 1'b1 || remap_update !== 1'b0) begin
            bad++; $display("FAIL zero_len: err=%b upd=%b exp 1 0", err, remap_update);
        end
        tick();
        total++; if (n_upd - b_upd != 1) begin bad++; $display("FAIL perm_upd_count: got=%0d exp=1", n_upd - b_upd); end
    endtask

    task test_gc_priority();
        int b_gc;
        b_gc = n_gcini;
        w_used = 16'hF000;
        req_valid = 1'b1; req_write = 1'b1; req_region = 2'd0; req_length = 16'd1;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL gcp_ready: got=%b exp=0", req_ready); end
        tick();
        total++; if (sys_mode !== 3'd3 || gc_ini !== 1'b1 || remap_update !== 1'b0) begin
            bad++; $display("FAIL gcp_ini: mode=%0d ini=%b upd=%b exp 3 1 0", sys_mode, gc_ini, remap_update);
        end
        tick();
        total++; if (sys_mode !== 3'd4 || gc_start !== 1'b1 || gc_ini !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL gcp_run: mode=%0d start=%b ini=%b rdy=%b exp 4 1 0 0", sys_mode, gc_start, gc_ini, req_ready);
        end
        w_used = 16'd0;
        tick();
        gc_done = 1'b1;
        tick();
        gc_done = 1'b0;
        total++; if (sys_mode !== 3'd0 || gc_start !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL gcp_exit: mode=%0d start=%b rdy=%b exp 0 0 1", sys_mode, gc_start, req_ready);
        end
        tick();
        req_valid = 1'b0;
        total++; if (remap_update !== 1'b1 || sys_mode !== 3'd1) begin
            bad++; $display("FAIL gcp_accept: upd=%b mode=%0d exp 1 1", remap_update, sys_mode);
        end
        complete_txn(1);
        total++; if (n_gcini - b_gc != 1) begin bad++; $display("FAIL gcp_ini_count: got=%0d exp=1", n_gcini - b_gc); end
    endtask

    task test_gc_interrupt();
        int b_gc;
        w_used = 16'hF000;
        tick();
        tick();
        total++; if (sys_mode !== 3'd4) begin bad++; $display("FAIL gci_run: got=%0d exp=4", sys_mode); end
        gc_interrupt = 1'b1;
        tick();
        gc_interrupt = 1'b0;
        b_gc = n_gcini;
        total++; if (sys_mode !== 3'd0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL gci_exit: mode=%0d rdy=%b exp 0 1", sys_mode, req_ready);
        end
        repeat (4) tick();
        total++; if (sys_mode !== 3'd0 || n_gcini != b_gc) begin
            bad++; $display("FAIL gci_no_reentry: mode=%0d gc_ini_pulses=%0d exp 0 0", sys_mode, n_gcini - b_gc);
        end
        w_used = 16'hEFFF;
        tick();
        w_used = 16'hF000;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL gci_rearm: rdy=%b exp=0", req_ready); end
        tick();
        total++; if (sys_mode !== 3'd3) begin bad++; $display("FAIL gci_reenter: mode=%0d exp=3", sys_mode); end
        tick();
        gc_done = 1'b1; gc_interrupt = 1'b1;
        tick();
        gc_done = 1'b0; gc_interrupt = 1'b0;
        total++; if (sys_mode !== 3'd0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL gci_both: mode=%0d rdy=%b exp 0 0", sys_mode, req_ready);
        end
        tick();
        total++; if (sys_mode !== 3'd3) begin bad++; $display("FAIL gci_still_armed: mode=%0d exp=3", sys_mode); end
        tick();
        w_used = 16'd0; gc_done = 1'b1;
        tick();
        gc_done = 1'b0;
        total++; if (sys_mode !== 3'd0) begin bad++; $display("FAIL gci_final: mode=%0d exp=0", sys_mode); end
    endtask

    task test_rfull();
        accept_req(1'b0, 2'd3, 16'h0010, 16'd2);
        remap_done = 1'b1;
        tick();
        remap_done = 1'b0;
        total++; if (sys_mode !== 3'd2 || txn_count !== 16'd2) begin
            bad++; $display("FAIL rf_busy: mode=%0d cnt=%0d exp 2 2", sys_mode, txn_count);
        end
        r_full = 1'b1; beat = 1'b1; gc_request = 1'b1; w_used = 16'hF000;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (txn_count !== 16'd2 || sys_mode !== 3'd2) begin
                bad++; $display("FAIL rf_hold%0d: cnt=%0d mode=%0d exp 2 2", i, txn_count, sys_mode);
            end
        end
        gc_request = 1'b0; w_used = 16'd0; r_full = 1'b0;
        tick();
        total++; if (txn_count !== 16'd1 || req_done !== 1'b0) begin
            bad++; $display("FAIL rf_beat1: cnt=%0d done=%b exp 1 0", txn_count, req_done);
        end
        tick();
        beat = 1'b0;
        total++; if (req_done !== 1'b1 || sys_mode !== 3'd0) begin
            bad++; $display("FAIL rf_done: done=%b mode=%0d exp 1 0", req_done, sys_mode);
        end
        tick();
    endtask

    task test_reset_mid();
        int b_done;
        accept_req(1'b1, 2'd0, 16'd0, 16'd5);
        remap_done = 1'b1;
        tick();
        remap_done = 1'b0;
        beat = 1'b1;
        tick();
        b_done = n_done;
        nRST = 1'b0;
        #1;
        total++; if (sys_mode !== 3'd0 || req_done !== 1'b0 || txn_count !== 16'd0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL rm_reset: mode=%0d done=%b cnt=%0d rdy=%b exp 0 0 0 0", sys_mode, req_done, txn_count, req_ready);
        end
        beat = 1'b0;
        repeat (2) tick();
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        tick();
        total++; if (req_ready !== 1'b1 || n_done != b_done) begin
            bad++; $display("FAIL rm_after: rdy=%b done_pulses=%0d exp 1 0", req_ready, n_done - b_done);
        end
        accept_req(1'b0, 2'd1, 16'd0, 16'd2);
        remap_done = 1'b1; remap_error = 1'b1;
        tick();
        remap_done = 1'b0; remap_error = 1'b0;
        total++; if (err !== 1'b1 || sys_mode !== 3'd0 || txn_count !== 16'd0) begin
            bad++; $display("FAIL rm_error_wins: err=%b mode=%0d cnt=%0d exp 1 0 0", err, sys_mode, txn_count);
        end
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rm_err_end: got=%b exp=0", err); end
    endtask

    // Randomized traffic against a transaction-level model of permissions and beat counting.
    task test_random();
        logic [NREG-1:0] perm_m;
        logic            wr, bad_req, rem_err, counted;
        logic [RW-1:0]   rg;
        int              len, left, t, b_upd, b_err, b_done;
        logic [5:0]      exp_code, obs_code;
        perm_m = 4'b1111;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                cfg_we = 1'b1;
                cfg_region = RW'($urandom_range(0, NREG - 1));
                cfg_perm = 1'($urandom_range(0, 1));
                tick();
                cfg_we = 1'b0;
                perm_m[cfg_region] = cfg_perm;
            end
            wr = 1'($urandom_range(0, 1));
            rg = RW'($urandom_range(0, NREG - 1));
            len = $urandom_range(0, 4);
            bad_req = (len == 0) || (wr && !perm_m[rg]);
            rem_err = !bad_req && ($urandom_range(0, 7) == 0);
            exp_q.push_back({2'(bad_req ? 0 : 1), 2'((bad_req || rem_err) ? 0 : 1),
                             2'((bad_req || rem_err) ? 1 : 0)});
            b_upd = n_upd; b_err = n_err; b_done = n_done;
            accept_req(wr, rg, BW'($urandom_range(0, 65535)), BW'(len));
            if (!bad_req) begin
                repeat ($urandom_range(0, 3)) tick();
                if (rem_err) remap_error = 1'b1;
                else         remap_done = 1'b1;
                tick();
                remap_error = 1'b0; remap_done = 1'b0;
                if (!rem_err) begin
                    left = len;
                    t = 0;
                    while (left > 0 && t < 200) begin
                        beat = 1'($urandom_range(0, 1));
                        r_full = 1'($urandom_range(0, 1));
                        counted = beat && (wr || !r_full);
                        tick();
                        t++;
                        if (counted) left--;
                        total++;
                        if (sys_mode !== ((left == 0) ? 3'd0 : 3'd2) || txn_count !== BW'(left)) begin
                            bad++;
                            $display("FAIL rnd_busy n=%0d: mode=%0d cnt=%0d exp mode=%0d cnt=%0d",
                                     n, sys_mode, txn_count, (left == 0) ? 0 : 2, left);
                        end
                    end
                    beat = 1'b0; r_full = 1'b0;
                end
            end
            tick();
            obs_code = {2'(n_upd - b_upd), 2'(n_done - b_done), 2'(n_err - b_err)};
            exp_code = exp_q.pop_front();
            total++;
            if (obs_code !== exp_code) begin
                bad++;
                $display("FAIL rnd_txn n=%0d: upd/done/err=%b exp=%b", n, obs_code, exp_code);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_perm();
        test_gc_priority();
        test_gc_interrupt();
        test_rfull();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
